// File: rtl/jtframe_spi_rx_if.sv
// SPI pin bundle plus the ROM-download and OSD write outputs of jtframe_spi_rx.
// The master side is the ARM/link side; the slave side is the FPGA receiver.
interface jtframe_spi_rx_if #(
  parameter int AW     = 22,
  parameter int OSD_AW = 11
);
  logic              SPI_SCK;
  logic              SPI_DI;
  logic              SPI_SS2;
  logic              SPI_SS3;
  logic              SPI_DO;
  logic              downloading;
  logic [7:0]        ioctl_index;
  logic [AW-1:0]     ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wr;
  logic              osd_en;
  logic [OSD_AW-1:0] osd_addr;
  logic [7:0]        osd_dout;
  logic              osd_wr;

  modport master (
    output SPI_SCK, SPI_DI, SPI_SS2, SPI_SS3,
    input  SPI_DO, downloading, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
           osd_en, osd_addr, osd_dout, osd_wr
  );

  modport slave (
    input  SPI_SCK, SPI_DI, SPI_SS2, SPI_SS3,
    output SPI_DO, downloading, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
           osd_en, osd_addr, osd_dout, osd_wr
  );
endinterface

// File: rtl/jtframe_spi_rx.sv
// SPI responder for the ARM-to-FPGA link. SS2 carries the file-transfer
// protocol (0x53 enable, 0x54 data, 0x55 index) turned into ioctl_* writes;
// SS3 carries OSD commands (0x20 image write, 0x40/0x41 OSD enable).
// SPI pins are oversampled in the clk domain.
module jtframe_spi_rx #(
  parameter int AW     = 22,
  parameter int OSD_AW = 11
) (
  input logic               clk,
  input logic               rst,
  jtframe_spi_rx_if.slave   bus
);

  localparam logic [2:0] ST_CMD    = 3'd0;
  localparam logic [2:0] ST_ARG53  = 3'd1;
  localparam logic [2:0] ST_ARG55  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_OSDW   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  logic [1:0] sck_sync_q, di_sync_q, ss2_sync_q, ss3_sync_q;
  logic       sck_prev_q, ss2_prev_q, ss3_prev_q;
  logic [2:0] bitcnt_q;
  logic [6:0] shift_q;
  logic       byte_rdy_q, byte_ch_q;
  logic [7:0] byte_q;

  logic [2:0]        state_q, state_d;
  logic              dl_q, dl_d;
  logic [7:0]        index_q, index_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              osd_en_q, osd_en_d;
  logic [OSD_AW-1:0] osd_addr_q, osd_addr_d;
  logic [7:0]        osd_dout_q, osd_dout_d;
  logic              osd_wr_q, osd_wr_d;

  // SS2 has priority: SS3 only counts as selected while SS2 is high.
  logic sck_rise, ss2_act, ss3_act, sel_act, sel_prev, new_frame;
  assign sck_rise  = sck_sync_q[1] & ~sck_prev_q;
  assign ss2_act   = ~ss2_sync_q[1];
  assign ss3_act   = ~ss3_sync_q[1] & ~ss2_act;
  assign sel_act   = ss2_act | ss3_act;
  assign sel_prev  = ss2_prev_q | ss3_prev_q;
  assign new_frame = (ss2_act & ~ss2_prev_q) | (ss3_act & ~ss3_prev_q);

  // Two-flop synchronisers and one-clk delayed copies for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q <= 2'b00;
      di_sync_q  <= 2'b00;
      ss2_sync_q <= 2'b11;
      ss3_sync_q <= 2'b11;
      sck_prev_q <= 1'b0;
      ss2_prev_q <= 1'b0;
      ss3_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], bus.SPI_SCK};
      di_sync_q  <= {di_sync_q[0],  bus.SPI_DI};
      ss2_sync_q <= {ss2_sync_q[0], bus.SPI_SS2};
      ss3_sync_q <= {ss3_sync_q[0], bus.SPI_SS3};
      sck_prev_q <= sck_sync_q[1];
      ss2_prev_q <= ss2_act;
      ss3_prev_q <= ss3_act;
    end
  end

  // Bit assembly. An SCK edge is accepted if the select was active the
  // previous clk, so a select rising together with the 8th edge still
  // completes the byte; otherwise a released select drops partial bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_q   <= 3'd0;
      shift_q    <= 7'd0;
      byte_rdy_q <= 1'b0;
      byte_q     <= 8'd0;
      byte_ch_q  <= 1'b0;
    end else begin
      byte_rdy_q <= 1'b0;
      if (sck_rise && sel_prev && !new_frame) begin
        shift_q  <= {shift_q[5:0], di_sync_q[1]};
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          byte_rdy_q <= 1'b1;
          byte_q     <= {shift_q, di_sync_q[1]};
          byte_ch_q  <= ss3_prev_q;
        end
      end else if (!sel_act || new_frame) begin
        bitcnt_q <= 3'd0;
        shift_q  <= 7'd0;
      end
    end
  end

  // Command decoder and write-strobe generation; addresses advance on the
  // strobe cycle so they hold the current byte's address while strobing.
  always_comb begin
    state_d    = state_q;
    dl_d       = dl_q;
    index_d    = index_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    wr_d       = 1'b0;
    osd_en_d   = osd_en_q;
    osd_addr_d = osd_addr_q;
    osd_dout_d = osd_dout_q;
    osd_wr_d   = 1'b0;
    if (wr_q)     addr_d     = addr_q + AW'(1);
    if (osd_wr_q) osd_addr_d = osd_addr_q + OSD_AW'(1);
    if (byte_rdy_q) begin
      case (state_q)
        ST_CMD: begin
          state_d = ST_IGNORE;
          if (!byte_ch_q) begin
            case (byte_q)
              8'h53:   state_d = ST_ARG53;
              8'h54:   state_d = ST_DATA;
              8'h55:   state_d = ST_ARG55;
              default: state_d = ST_IGNORE;
            endcase
          end else if (byte_q == 8'h20) begin
            state_d    = ST_OSDW;
            osd_addr_d = '0;
          end else if (byte_q[7:1] == 7'h20) begin
            osd_en_d = byte_q[0];
          end
        end
        ST_ARG53: begin
          dl_d = byte_q[0];
          if (byte_q[0] && !dl_q) addr_d = '0;
          state_d = ST_IGNORE;
        end
        ST_ARG55: begin
          index_d = byte_q;
          state_d = ST_IGNORE;
        end
        ST_DATA: begin
          if (dl_q) begin
            dout_d = byte_q;
            wr_d   = 1'b1;
          end
        end
        ST_OSDW: begin
          osd_dout_d = byte_q;
          osd_wr_d   = 1'b1;
        end
        default: ;
      endcase
    end
    if (new_frame) state_d = ST_CMD;
  end

  // Decoder state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CMD;
      dl_q       <= 1'b0;
      index_q    <= 8'd0;
      addr_q     <= '0;
      dout_q     <= 8'd0;
      wr_q       <= 1'b0;
      osd_en_q   <= 1'b0;
      osd_addr_q <= '0;
      osd_dout_q <= 8'd0;
      osd_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      index_q    <= index_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      osd_en_q   <= osd_en_d;
      osd_addr_q <= osd_addr_d;
      osd_dout_q <= osd_dout_d;
      osd_wr_q   <= osd_wr_d;
    end
  end

  assign bus.SPI_DO      = 1'b0;
  assign bus.downloading = dl_q;
  assign bus.ioctl_index = index_q;
  assign bus.ioctl_addr  = addr_q;
  assign bus.ioctl_dout  = dout_q;
  assign bus.ioctl_wr    = wr_q;
  assign bus.osd_en      = osd_en_q;
  assign bus.osd_addr    = osd_addr_q;
  assign bus.osd_dout    = osd_dout_q;
  assign bus.osd_wr      = osd_wr_q;

endmodule

// File: tb/tb_jtframe_spi_rx.sv
// Directed testbench for jtframe_spi_rx: drives SPI frames on SS2/SS3 and
// checks the download and OSD write streams against hand-computed values.
module tb_jtframe_spi_rx;
  localparam int AW     = 22;
  localparam int OSD_AW = 8;
  localparam int HALF   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jtframe_spi_rx_if #(.AW(AW), .OSD_AW(OSD_AW)) bus();
  jtframe_spi_rx #(.AW(AW), .OSD_AW(OSD_AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Strobe logs, filled by the monitor; tests look at entries after a base.
  int                wr_cnt = 0;
  logic [AW-1:0]     wr_addr [0:1023];
  logic [7:0]        wr_dout [0:1023];
  int                osd_cnt = 0;
  logic [OSD_AW-1:0] osd_addr_log [0:1023];
  logic [7:0]        osd_dout_log [0:1023];

  always @(negedge clk) begin
    if (bus.ioctl_wr === 1'b1 && wr_cnt < 1024) begin
      wr_addr[wr_cnt] = bus.ioctl_addr;
      wr_dout[wr_cnt] = bus.ioctl_dout;
      wr_cnt = wr_cnt + 1;
    end
    if (bus.osd_wr === 1'b1 && osd_cnt < 1024) begin
      osd_addr_log[osd_cnt] = bus.osd_addr;
      osd_dout_log[osd_cnt] = bus.osd_dout;
      osd_cnt = osd_cnt + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits = 8);
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.SPI_DI  = b[i];
      bus.SPI_SCK = 1'b0;
      wait_clk(HALF);
      bus.SPI_SCK = 1'b1;
      wait_clk(HALF);
    end
    bus.SPI_SCK = 1'b0;
  endtask

  task automatic sel_lo(input bit osd);
    if (osd) bus.SPI_SS3 = 1'b0;
    else     bus.SPI_SS2 = 1'b0;
    wait_clk(4);
  endtask

  task automatic sel_hi();
    wait_clk(8);
    bus.SPI_SS2 = 1'b1;
    bus.SPI_SS3 = 1'b1;
    wait_clk(10);
  endtask

  task automatic cmd2(input logic [7:0] b0, input logic [7:0] b1);
    sel_lo(1'b0);
    spi_byte(b0);
    spi_byte(b1);
    sel_hi();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    wait_clk(3);
    checks++; if (bus.downloading !== 1'b0) begin errors++; $display("FAIL reset_downloading: got %0h expected 0", bus.downloading); end
    checks++; if (bus.ioctl_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.ioctl_addr); end
    checks++; if (bus.ioctl_index !== 8'h00) begin errors++; $display("FAIL reset_index: got %0h expected 0", bus.ioctl_index); end
    checks++; if ({bus.ioctl_wr, bus.osd_wr, bus.osd_en, bus.SPI_DO} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.ioctl_wr, bus.osd_wr, bus.osd_en, bus.SPI_DO}); end
    checks++; if ({bus.ioctl_dout, bus.osd_dout, bus.osd_addr} !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", {bus.ioctl_dout, bus.osd_dout, bus.osd_addr}); end
    rst = 1'b0;
    wait_clk(3);
  endtask

  task automatic test_download();
    logic [7:0] data [0:3];
    int base;
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
    sel_lo(1'b0);
    spi_byte(8'h53);
    wait_clk(3);
    checks++; if (bus.downloading !== 1'b0) begin errors++; $display("FAIL dl_after_cmd: got %0h expected 0", bus.downloading); end
    spi_byte(8'h01);
    wait_clk(3);
    checks++; if (bus.downloading !== 1'b1) begin errors++; $display("FAIL dl_after_arg: got %0h expected 1", bus.downloading); end
    sel_hi();
    base = wr_cnt;
    sel_lo(1'b0);
    spi_byte(8'h54);
    for (int k = 0; k < 4; k++) spi_byte(data[k]);
    sel_hi();
    checks++; if (wr_cnt - base !== 4) begin errors++; $display("FAIL dl_wr_count: got %0d expected 4", wr_cnt - base); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (wr_addr[base+k] !== AW'(k)) begin errors++; $display("FAIL dl_addr[%0d]: got %0h expected %0h", k, wr_addr[base+k], k); end
      checks++; if (wr_dout[base+k] !== data[k]) begin errors++; $display("FAIL dl_dout[%0d]: got %0h expected %0h", k, wr_dout[base+k], data[k]); end
    end
    cmd2(8'h53, 8'h00);
    checks++; if (bus.downloading !== 1'b0) begin errors++; $display("FAIL dl_end: got %0h expected 0", bus.downloading); end
    checks++; if (bus.ioctl_addr !== AW'(4)) begin errors++; $display("FAIL dl_final_addr: got %0h expected 4", bus.ioctl_addr); end
  endtask

  task automatic test_index();
    int base;
    base = wr_cnt;
    cmd2(8'h55, 8'h07);
    checks++; if (bus.ioctl_index !== 8'h07) begin errors++; $display("FAIL index: got %0h expected 07", bus.ioctl_index); end
    checks++; if (wr_cnt !== base) begin errors++; $display("FAIL index_no_wr: got %0d expected %0d", wr_cnt, base); end
    checks++; if (bus.downloading !== 1'b0) begin errors++; $display("FAIL index_dl: got %0h expected 0", bus.downloading); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] v;
    cmd2(8'h53, 8'h01);
    base = wr_cnt;
    for (int i = 0; i < 300; i++) begin
      v = 8'(i * 7 + 3);
      bus.SPI_SS2 = 1'b0;
      wait_clk(4);
      spi_byte(8'h54);
      spi_byte(v);
      wait_clk(8);
      bus.SPI_SS2 = 1'b1;
      wait_clk(10);
    end
    checks++; if (wr_cnt - base !== 300) begin errors++; $display("FAIL b2b_count: got %0d expected 300", wr_cnt - base); end
    for (int i = 0; i < 300; i++) begin
      v = 8'(i * 7 + 3);
      checks++; if (wr_addr[base+i] !== AW'(i)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0h expected %0h", i, wr_addr[base+i], i); end
      checks++; if (wr_dout[base+i] !== v) begin errors++; $display("FAIL b2b_dout[%0d]: got %0h expected %0h", i, wr_dout[base+i], v); end
    end
    checks++; if (bus.ioctl_addr !== AW'(300)) begin errors++; $display("FAIL b2b_final_addr: got %0h expected 12c", bus.ioctl_addr); end
    cmd2(8'h53, 8'h00);
  endtask

  task automatic test_osd();
    int base, wbase;
    base  = osd_cnt;
    wbase = wr_cnt;
    sel_lo(1'b1);
    spi_byte(8'h20);
    for (int i = 0; i < 256; i++) spi_byte(8'hAA);
    sel_hi();
    checks++; if (osd_cnt - base !== 256) begin errors++; $display("FAIL osd_count: got %0d expected 256", osd_cnt - base); end
    for (int i = 0; i < 256; i++) begin
      checks++; if (osd_addr_log[base+i] !== OSD_AW'(i) || osd_dout_log[base+i] !== 8'hAA) begin errors++; $display("FAIL osd_wr[%0d]: got addr %0h data %0h expected addr %0h data aa", i, osd_addr_log[base+i], osd_dout_log[base+i], i); end
    end
    checks++; if (bus.osd_addr !== '0) begin errors++; $display("FAIL osd_wrap: got %0h expected 0", bus.osd_addr); end
    checks++; if (wr_cnt !== wbase) begin errors++; $display("FAIL osd_no_ioctl: got %0d expected %0d", wr_cnt, wbase); end
    sel_lo(1'b1); spi_byte(8'h41); sel_hi();
    checks++; if (bus.osd_en !== 1'b1) begin errors++; $display("FAIL osd_en_on: got %0h expected 1", bus.osd_en); end
    sel_lo(1'b1); spi_byte(8'h40); sel_hi();
    checks++; if (bus.osd_en !== 1'b0) begin errors++; $display("FAIL osd_en_off: got %0h expected 0", bus.osd_en); end
    // Both selects low: SS2 owns the byte, so 0x41 is an unknown SS2 command.
    bus.SPI_SS2 = 1'b0;
    bus.SPI_SS3 = 1'b0;
    wait_clk(4);
    spi_byte(8'h41);
    sel_hi();
    checks++; if (bus.osd_en !== 1'b0) begin errors++; $display("FAIL ss2_priority: got %0h expected 0", bus.osd_en); end
  endtask

  task automatic test_partial();
    int base;
    cmd2(8'h53, 8'h01);
    base = wr_cnt;
    sel_lo(1'b0);
    spi_byte(8'h54);
    spi_byte(8'hFF, 5);
    wait_clk(4);
    bus.SPI_SS2 = 1'b1;
    wait_clk(10);
    sel_lo(1'b0);
    spi_byte(8'h54);
    spi_byte(8'h5A);
    sel_hi();
    checks++; if (wr_cnt - base !== 1) begin errors++; $display("FAIL partial_count: got %0d expected 1", wr_cnt - base); end
    checks++; if (wr_dout[base] !== 8'h5A) begin errors++; $display("FAIL partial_dout: got %0h expected 5a", wr_dout[base]); end
    checks++; if (wr_addr[base] !== AW'(0)) begin errors++; $display("FAIL partial_addr: got %0h expected 0", wr_addr[base]); end
  endtask

  task automatic test_reset_mid();
    int base;
    sel_lo(1'b1); spi_byte(8'h41); sel_hi();
    cmd2(8'h55, 8'h09);
    cmd2(8'h53, 8'h00);
    cmd2(8'h53, 8'h01);
    sel_lo(1'b0);
    spi_byte(8'h54);
    for (int i = 0; i < 100; i++) spi_byte(8'(i));
    wait_clk(6);
    checks++; if (bus.ioctl_addr !== AW'(100)) begin errors++; $display("FAIL mid_addr: got %0h expected 64", bus.ioctl_addr); end
    spi_byte(8'hF0, 3);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.downloading, bus.osd_en, bus.ioctl_wr, bus.osd_wr} !== 4'b0000) begin errors++; $display("FAIL async_rst_flags: got %b expected 0000", {bus.downloading, bus.osd_en, bus.ioctl_wr, bus.osd_wr}); end
    checks++; if (bus.ioctl_addr !== '0) begin errors++; $display("FAIL async_rst_addr: got %0h expected 0", bus.ioctl_addr); end
    checks++; if (bus.ioctl_index !== 8'h00) begin errors++; $display("FAIL async_rst_index: got %0h expected 0", bus.ioctl_index); end
    wait_clk(2);
    bus.SPI_SS2 = 1'b1;
    rst = 1'b0;
    wait_clk(10);
    cmd2(8'h53, 8'h01);
    base = wr_cnt;
    sel_lo(1'b0);
    spi_byte(8'h54);
    spi_byte(8'hC3);
    sel_hi();
    checks++; if (wr_cnt - base !== 1) begin errors++; $display("FAIL restart_count: got %0d expected 1", wr_cnt - base); end
    checks++; if (wr_addr[base] !== AW'(0) || wr_dout[base] !== 8'hC3) begin errors++; $display("FAIL restart_wr: got addr %0h data %0h expected addr 0 data c3", wr_addr[base], wr_dout[base]); end
  endtask

  initial begin
    bus.SPI_SCK = 1'b0;
    bus.SPI_DI  = 1'b0;
    bus.SPI_SS2 = 1'b1;
    bus.SPI_SS3 = 1'b1;
    test_reset();
    test_download();
    test_index();
    test_back_to_back();
    test_osd();
    test_partial();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtframe_spi_rx.md
Name: jtframe_spi_rx

Overview:
- SPI responder (MiST data_io style) for the FPGA side of the ARM-to-FPGA link; the ARM is the SPI initiator.
- Decodes the SS2 file-transfer protocol (0x53/0x54/0x55) into a byte-wide ROM download interface: ioctl_* write strobes, address and index.
- Decodes SS3 OSD commands: 0x20 image write, 0x40/0x41 OSD enable.
- Sits between the SPI pins and the ROM loader/SDRAM writer; OSD bytes feed the OSD frame buffer.

Parameters:
- AW, 22, ioctl_addr width; address wraps modulo 2^AW.
- OSD_AW, 11, osd_addr width (2048-byte OSD image).

Ports:
- clk  in  1  system clock; SPI signals are oversampled in this domain.
- rst  in  1  asynchronous, active-high reset.
- SPI_SCK  in  1  SPI clock from the ARM; data sampled on its rising edge.
- SPI_DI  in  1  serial data, MSB first.
- SPI_SS2  in  1  active-low select, file-transfer channel.
- SPI_SS3  in  1  active-low select, OSD channel.
- SPI_DO  out  1  constant 0 (no read-back).
- downloading  out  1  high while a ROM transfer is active.
- ioctl_index  out  8  file index from the 0x55 command.
- ioctl_addr  out  AW  byte address of the current/next download byte.
- ioctl_dout  out  8  download data byte.
- ioctl_wr  out  1  one-clk write strobe.
- osd_en  out  1  OSD visible.
- osd_addr  out  OSD_AW  OSD image byte address.
- osd_dout  out  8  OSD image byte.
- osd_wr  out  1  one-clk OSD write strobe.

Behaviour:
- Reset values: all outputs 0, including downloading, ioctl_index, ioctl_addr, osd_en and the strobes. Reset mid-transfer aborts immediately: downloading=0, partial byte lost.
- Input path: SCK, DI, SS2 and SS3 each pass through a 2-flop synchroniser. An SCK rising edge is detected from the synchronised samples and shifts the synchronised DI into the shift register.
- SCK high and SCK low must each last at least 2 clk.
- Bit counter is 3 bits. The 8th edge produces byte_rdy for one clk.
- Any select high clears the bit counter and the partial byte. A rising edge of the active select mid-byte discards the partial bits.
- Channel priority: SS2 wins. SS3 edges are ignored while SS2 is low.
- Per-select FSM (re-entered on every select falling edge):
  - CMD: first byte is the command.
  - 0x53 -> ARG53; 0x54 -> DATA; 0x55 -> ARG55; 0x20 (SS3) -> OSDW.
  - 0x40/0x41 (SS3): osd_en = cmd[0], then IGNORE.
  - Any other command -> IGNORE until the select deasserts.
- ARG53: next byte bit0 -> downloading.
  - A 0->1 transition of downloading clears ioctl_addr to 0.
  - A 1->0 transition leaves ioctl_addr at the final count.
  - Then IGNORE.
- ARG55: next byte -> ioctl_index, then IGNORE.
- DATA: every byte while downloading=1:
  - ioctl_dout = byte, ioctl_wr = 1 for exactly 1 clk, one clk after byte_rdy.
  - ioctl_addr holds that byte's address during the strobe and increments on the strobe cycle.
  - Bytes received while downloading=0 are discarded (no strobe).
- OSDW:
  - Entry clears osd_addr.
  - Each byte -> osd_dout, osd_wr 1 clk with the same timing as ioctl_wr, osd_addr increments; wraps at 2^OSD_AW.
- Latency: last SCK rise of a byte -> strobe high within 5 clk (2 sync + edge + byte_rdy + strobe); fixed for a given implementation.
- ioctl_addr wraps 2^AW-1 -> 0 silently.
- Select rising edge on the same clk as byte_rdy: the byte completes and is processed.

Test Plan:
- SS2: 0x53,0x01 | 0x54, 4 bytes 0x11,0x22,0x33,0x44 | 0x53,0x00 -> downloading rises after 2nd byte; 4 ioctl_wr pulses at addr 0..3 with matching dout; downloading falls; ioctl_addr=4.
- SS2: 0x55,0x07 -> ioctl_index=7, no strobes, downloading unchanged.
- Download of 300 bytes, SS2 deasserted for 10 clk between each byte (separate 0x54 frames) -> 300 strobes, addresses contiguous 0..299.
- SS3: 0x20 + 2048 x 0xAA -> 2048 osd_wr, osd_addr 0..2047 then wraps to 0; then SS3 0x41 -> osd_en=1; 0x40 -> osd_en=0.
- SS2 raised after 5 bits of a data byte, then a new 0x54 frame with byte 0x5A -> partial byte dropped, single strobe dout=0x5A.
- rst pulsed mid-download at addr 100 -> all outputs 0 asynchronously; restart with 0x53,0x01 gives addr 0 on first write.
